// File: rtl/mmio_fabric.sv
// ============================================================================
// mmio_fabric
//
// Single-master MMIO address decoder and completion tracker. A CPU port is
// decoded combinationally onto N_SLV peripheral windows, a status register,
// a mask register and data memory (the default target). Each slave has a
// small IDLE/BUSY/DONE/ERR tracker. A store to offset 0 of a window starts
// the tracker. A rising slv_done ends it, and a busy timeout flags an error.
// DONE and ERR are cleared by write-1-to-clear on the status register.
//
// Status word: [7:0] done, [15:8] busy, [23:16] timeout error, [31:24] zero.
//
// Optional feature (macro MMIO_FABRIC_IRQ_EN):
//   defined   : 8-bit mask register at STAT_ADDR+4 (read/write), and
//               irq <= |((done | err) & mask), one cycle of latency.
//   undefined : no mask register, irq tied 0, STAT_ADDR+4 reads 0 and
//               ignores writes (it still never decodes to memory).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   we         in   CPU store strobe
//   addr       in   CPU byte address (bits [1:0] ignored)
//   wdata      in   CPU store data
//   rdata      out  CPU load data (combinational)
//   mem_we     out  data-memory write enable (combinational)
//   mem_rdata  in   data-memory read data
//   slv_we     out  per-slave write enable (combinational)
//   slv_rdata  in   slave read data, slave i at [i*DATA_W +: DATA_W]
//   slv_done   in   per-slave done level, synchronous to clk
//   irq        out  interrupt request
// ============================================================================
module mmio_fabric #(
    parameter int          N_SLV     = 4,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE      = 32'h0000_0800,
    parameter int          SLV_AW    = 5,
    parameter logic [31:0] STAT_ADDR = 32'h0000_0F00,
    parameter int          TMO_CYC   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [31:0]             addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_we,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [N_SLV-1:0]        slv_we,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    input  logic [N_SLV-1:0]        slv_done,
    output logic                    irq
);

    localparam int          TW       = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam logic [31:0] WIN_SZ   = 32'd1 << SLV_AW;
    localparam logic [31:0] WIN_SPAN = 32'(N_SLV) << SLV_AW;
    localparam logic [31:0] STAT_W   = STAT_ADDR & ~32'h3;
    localparam logic [31:0] MASK_W   = STAT_W + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } slv_state_t;

    // ------------------------------------------------------------------
    // Address decode (one target per cycle, windows take priority)
    // ------------------------------------------------------------------
    logic [31:0]      word_addr;
    logic [31:0]      win_off;
    logic             in_win;
    logic             at_off0;
    logic             hit_stat;
    logic             hit_mask;
    logic             hit_mem;
    logic             stat_wr;
    logic [N_SLV-1:0] hit_slv;
    logic [N_SLV-1:0] start;

    assign word_addr = addr & ~32'h3;
    assign win_off   = word_addr - BASE;
    assign in_win    = (word_addr >= BASE) && (win_off < WIN_SPAN);
    assign at_off0   = (win_off & (WIN_SZ - 32'd1)) == 32'd0;
    assign hit_stat  = !in_win && (word_addr == STAT_W);
    assign hit_mask  = !in_win && !hit_stat && (word_addr == MASK_W);
    assign hit_mem   = !(in_win || hit_stat || hit_mask);
    assign stat_wr   = we && hit_stat;
    assign mem_we    = we && hit_mem;

    // ------------------------------------------------------------------
    // Done edge detection
    // ------------------------------------------------------------------
    logic [N_SLV-1:0] done_smp_q;
    logic [N_SLV-1:0] done_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_smp_q <= '0;
        end else begin
            done_smp_q <= slv_done;
        end
    end

    assign done_rise = slv_done & ~done_smp_q;

    // ------------------------------------------------------------------
    // Per-slave trackers
    // ------------------------------------------------------------------
    logic [N_SLV-1:0] st_busy;
    logic [N_SLV-1:0] st_done;
    logic [N_SLV-1:0] st_err;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLV; gi++) begin : g_slv
            slv_state_t     state_q, state_d;
            logic [TW-1:0]  timer_q, timer_d;
            logic           tmo_hit;

            assign hit_slv[gi] = in_win && ((win_off >> SLV_AW) == 32'(gi));
            assign slv_we[gi]  = we && hit_slv[gi];
            assign start[gi]   = we && hit_slv[gi] && at_off0;

            if (TMO_CYC > 0) begin : g_tmo
                assign tmo_hit = (timer_q == TW'(TMO_CYC - 1));
            end else begin : g_no_tmo
                assign tmo_hit = 1'b0;
            end

            // Priority: start, then done_rise, then timeout.
            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                if (start[gi]) begin
                    state_d = ST_BUSY;
                    timer_d = '0;
                end else begin
                    case (state_q)
                        ST_BUSY: begin
                            if (done_rise[gi]) begin
                                state_d = ST_DONE;
                            end else if (tmo_hit) begin
                                state_d = ST_ERR;
                            end else begin
                                timer_d = timer_q + TW'(1);
                            end
                        end
                        ST_DONE: begin
                            if (stat_wr && wdata[gi]) begin
                                state_d = ST_IDLE;
                            end
                        end
                        ST_ERR: begin
                            if (stat_wr && wdata[16 + gi]) begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                end else begin
                    state_q <= state_d;
                    timer_q <= timer_d;
                end
            end

            assign st_busy[gi] = (state_q == ST_BUSY);
            assign st_done[gi] = (state_q == ST_DONE);
            assign st_err[gi]  = (state_q == ST_ERR);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Status word
    // ------------------------------------------------------------------
    logic [7:0]  done_v;
    logic [7:0]  busy_v;
    logic [7:0]  err_v;
    logic [31:0] status_w;

    assign done_v   = 8'(st_done);
    assign busy_v   = 8'(st_busy);
    assign err_v    = 8'(st_err);
    assign status_w = {8'h00, err_v, busy_v, done_v};

    // ------------------------------------------------------------------
    // Optional interrupt mask
    // ------------------------------------------------------------------
    logic [7:0] mask_rd;

`ifdef MMIO_FABRIC_IRQ_EN
    logic [7:0] mask_q, mask_d;
    logic       irq_q, irq_d;

    always_comb begin
        mask_d = mask_q;
        if (we && hit_mask) begin
            mask_d = wdata[7:0];
        end
        irq_d = |((done_v | err_v) & mask_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign mask_rd = mask_q;
    assign irq     = irq_q;
`else
    assign mask_rd = 8'h00;
    assign irq     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = mem_rdata;
        if (in_win) begin
            for (int i = 0; i < N_SLV; i++) begin
                if (hit_slv[i]) begin
                    rdata = slv_rdata[i*DATA_W +: DATA_W];
                end
            end
        end else if (hit_stat) begin
            rdata = DATA_W'(status_w);
        end else if (hit_mask) begin
            rdata = DATA_W'({24'h0, mask_rd});
        end
    end

    // Only some store-data bits drive state; fold the rest away.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_mmio_fabric.sv
// ============================================================================
// tb_mmio_fabric
//
// Self-checking bench for mmio_fabric (N_SLV=4, TMO_CYC=8). Directed
// scenarios run first, then randomized traffic. Every cycle the outputs are
// compared against a reference model that tracks each slave's status as
// plain integers and decodes addresses arithmetically.
// ============================================================================
module tb_mmio_fabric;

    localparam int          N    = 4;
    localparam int          DW   = 32;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h0000_0800;
    localparam logic [31:0] STAT = 32'h0000_0F00;
`ifdef MMIO_FABRIC_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [31:0]     addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic            mem_we;
    logic [DW-1:0]   mem_rdata;
    logic [N-1:0]    slv_we;
    logic [N*DW-1:0] slv_rdata;
    logic [N-1:0]    slv_done;
    logic            irq;

    always #5 clk = ~clk;

    mmio_fabric #(
        .N_SLV     (N),
        .DATA_W    (DW),
        .BASE      (BASE),
        .SLV_AW    (5),
        .STAT_ADDR (STAT),
        .TMO_CYC   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .slv_we    (slv_we),
        .slv_rdata (slv_rdata),
        .slv_done  (slv_done),
        .irq       (irq)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // state per slave: 0 idle, 1 busy, 2 done, 3 error
    int           m_state [N];
    int           m_age   [N];
    logic [N-1:0] m_done_prev;
    logic [7:0]   m_mask;
    logic         m_irq;

    logic [31:0]  last_rd;
    logic [N-1:0] last_swe;
    logic         last_mwe;
    logic [N-1:0] cur_done;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_age[i]   = 0;
        end
        m_done_prev = '0;
        m_mask      = 8'h00;
        m_irq       = 1'b0;
    endtask

    // 0..N-1 slave, 8 status, 9 mask, 10 memory
    function automatic int target(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w >= BASE && w < BASE + N * 32) return int'((w - BASE) / 32);
        if (w == STAT) return 8;
        if (w == STAT + 4) return 9;
        return 10;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < N; i++) begin
            if (m_state[i] == 1) s[8 + i]  = 1'b1;
            if (m_state[i] == 2) s[i]      = 1'b1;
            if (m_state[i] == 3) s[16 + i] = 1'b1;
        end
        return s;
    endfunction

    // One bus cycle, entered and left at a falling edge.
    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [N-1:0] dn);
        int           t;
        logic [31:0]  exp_rd;
        logic [N-1:0] exp_swe;
        logic [N-1:0] rise;
        logic [31:0]  wa;
        logic [31:0]  s_pre;
        logic         irq_next;

        check_val("irq", 32'(irq), 32'(m_irq));
        we        = w;
        addr      = a;
        wdata     = wd;
        slv_done  = dn;
        mem_rdata = $urandom;
        for (int i = 0; i < N; i++) slv_rdata[i*DW +: DW] = $urandom;
        #1;
        t  = target(a);
        wa = {a[31:2], 2'b00};
        if (t < N)        exp_rd = slv_rdata[t*DW +: DW];
        else if (t == 8)  exp_rd = m_status();
        else if (t == 9)  exp_rd = IRQ_ON ? {24'h0, m_mask} : 32'h0;
        else              exp_rd = mem_rdata;
        exp_swe = (w && t < N) ? N'(1 << t) : '0;
        last_rd  = rdata;
        last_swe = slv_we;
        last_mwe = mem_we;
        check_val("rdata", rdata, exp_rd);
        check_val("slv_we", 32'(slv_we), 32'(exp_swe));
        check_val("mem_we", 32'(mem_we), 32'(w && t == 10));
        $display("txn %0d we=%b addr=%h wdata=%h done=%b rdata=%h slv_we=%b mem_we=%b irq=%b",
                 txn, w, a, wd, dn, rdata, slv_we, mem_we, irq);
        txn++;
        @(posedge clk);
        s_pre    = m_status();
        irq_next = IRQ_ON && (|((s_pre[7:0] | s_pre[23:16]) & m_mask));
        rise     = dn & ~m_done_prev;
        for (int i = 0; i < N; i++) begin
            if (w && t == i && ((wa - BASE) % 32) == 0) begin
                m_state[i] = 1;
                m_age[i]   = 0;
            end else if (m_state[i] == 1) begin
                if (rise[i]) m_state[i] = 2;
                else if (TMO > 0 && m_age[i] == TMO - 1) m_state[i] = 3;
                else m_age[i]++;
            end else if (m_state[i] == 2) begin
                if (w && t == 8 && wd[i]) m_state[i] = 0;
            end else if (m_state[i] == 3) begin
                if (w && t == 8 && wd[16 + i]) m_state[i] = 0;
            end
        end
        if (IRQ_ON && w && t == 9) m_mask = wd[7:0];
        m_done_prev = dn;
        m_irq       = irq_next;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        we        = 1'b0;
        addr      = STAT;
        wdata     = '0;
        mem_rdata = '0;
        slv_rdata = '0;
        slv_done  = '0;
        cur_done  = '0;
        m_reset();

        // During reset: status empty, irq low, decode still live.
        #12;
        check_val("rst_stat", rdata, 32'h0);
        check_val("rst_irq", 32'(irq), 32'h0);
        we   = 1'b1;
        addr = BASE;
        #1;
        check_val("rst_slv_we", 32'(slv_we), 32'h1);
        we   = 1'b0;
        addr = STAT;
        @(negedge clk);
        rst = 1'b1;

        // Start slave 0.
        cycle(1'b1, 32'h800, 32'd5, 4'b0000);
        check_val("t1_slv_we", 32'(last_swe), 32'h1);
        check_val("t1_mem_we", 32'(last_mwe), 32'h0);
        cycle(1'b0, STAT, 32'h0, 4'b0000);
        check_val("t1_stat", last_rd, 32'h0000_0100);

        // Done rise, then W1C.
        cycle(1'b0, 32'h100, 32'h0, 4'b0001);
        cycle(1'b0, STAT, 32'h0, 4'b0001);
        check_val("t2_done", last_rd, 32'h0000_0001);
        cycle(1'b1, STAT, 32'h1, 4'b0001);
        cycle(1'b0, STAT, 32'h0, 4'b0001);
        check_val("t2_clr", last_rd, 32'h0);
        cycle(1'b0, STAT, 32'h0, 4'b0000);

        // Timeout on slave 1.
        cycle(1'b1, 32'h820, 32'h0, 4'b0000);
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b0, STAT, 32'h0, 4'b0000);
            if (k == 8) check_val("t3_busy", last_rd, 32'h0000_0200);
            if (k == 9) check_val("t3_err", last_rd, 32'h0002_0000);
        end
        cycle(1'b1, STAT, 32'h0002_0000, 4'b0000);
        cycle(1'b0, STAT, 32'h0, 4'b0000);
        check_val("t3_clr", last_rd, 32'h0);

        // Restart on slave 2 coinciding with its done rise.
        cycle(1'b1, 32'h840, 32'h0, 4'b0000);
        cycle(1'b0, 32'h10, 32'h0, 4'b0000);
        cycle(1'b1, 32'h840, 32'h0, 4'b0100);
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b0, STAT, 32'h0, 4'b0100);
            if (k == 8) check_val("t4_busy", last_rd, 32'h0000_0400);
            if (k == 9) check_val("t4_err", last_rd, 32'h0004_0000);
        end
        cycle(1'b1, STAT, 32'h0004_0000, 4'b0100);
        cycle(1'b0, STAT, 32'h0, 4'b0000);
        check_val("t4_clr", last_rd, 32'h0);

        // Mask register and interrupt.
        cycle(1'b1, STAT + 4, 32'h1, 4'b0000);
        cycle(1'b0, STAT + 4, 32'h0, 4'b0000);
        check_val("t5_mask", last_rd, IRQ_ON ? 32'h1 : 32'h0);
        cycle(1'b1, 32'h800, 32'h0, 4'b0000);
        cycle(1'b0, 32'h20, 32'h0, 4'b0001);
        cycle(1'b0, STAT, 32'h0, 4'b0001);
        check_val("t5_irq1", 32'(irq), IRQ_ON ? 32'h1 : 32'h0);
        cycle(1'b1, STAT, 32'h1, 4'b0001);
        cycle(1'b0, STAT, 32'h0, 4'b0000);
        check_val("t5_irq0", 32'(irq), 32'h0);

        // Reset while busy with slv_done held high.
        cycle(1'b0, 32'h30, 32'h0, 4'b1111);
        cycle(1'b1, 32'h800, 32'h0, 4'b1111);
        cycle(1'b1, 32'h860, 32'h0, 4'b1111);
        cycle(1'b0, STAT, 32'h0, 4'b1111);
        check_val("t6_busy", last_rd, 32'h0000_0900);
        we   = 1'b0;
        addr = STAT;
        #2 rst = 1'b0;
        #1;
        check_val("t6_rst_stat", rdata, 32'h0);
        check_val("t6_rst_irq", 32'(irq), 32'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 32'h800, 32'h0, 4'b1111);
        cycle(1'b0, STAT, 32'h0, 4'b1111);
        cycle(1'b0, STAT, 32'h0, 4'b1111);
        check_val("t6_nodone", last_rd, 32'h0000_0100);
        cycle(1'b0, STAT, 32'h0, 4'b1110);
        cycle(1'b0, STAT, 32'h0, 4'b1111);
        cycle(1'b0, STAT, 32'h0, 4'b1111);
        check_val("t6_done", last_rd, 32'h0000_0001);
        cycle(1'b1, STAT, 32'h1, 4'b1111);
        cur_done = 4'b1111;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic        w;
            int          sel;
            int          s;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) cur_done[i] = ~cur_done[i];
            end
            sel = int'($urandom_range(0, 5));
            s   = int'($urandom_range(0, N - 1));
            case (sel)
                0:       a = BASE + 32'(s * 32) + 32'($urandom_range(0, 3));
                1:       a = BASE + 32'(s * 32) + 32'(4 * $urandom_range(1, 7));
                2:       a = STAT + 32'($urandom_range(0, 3));
                3:       a = STAT + 32'd4;
                4:       a = ($urandom_range(0, 1) == 1) ? 32'h880 : 32'($urandom_range(0, 32'h7FF));
                default: a = 32'h1000 + $urandom;
            endcase
            w = 1'($urandom_range(0, 1));
            cycle(w, a, $urandom, cur_done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
